dlfloat_cmp_pipe: RTL

Parametrised, pipelined floating-point compare and reduce unit for the DLFloat family (default DLFloat16: 1 sign, 6 exponent, 9 mantissa bits). It supports per-beat min, max, eq, lt and le. It also supports streaming min/max reduction over a vector, returning the extremum and its index. Operands enter over a valid/ready handshake and results leave over a second valid/ready handshake. It sits beside the FPU arithmetic blocks and shares their 5-bit exception format.

---
 rtl/dlfloat_cmp_pipe.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/dlfloat_cmp_pipe.sv
// DLFloat compare/select unit with streaming min/max reduction.
// Two-stage pipeline (S1 result/accumulator, S2 output) with a single global advance enable.
module dlfloat_cmp_pipe #(
    parameter int unsigned EXP_W = 6,
    parameter int unsigned MAN_W = 9,
    parameter int unsigned IDX_W = 8,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic [4:0]       out_flags
);

    localparam logic [2:0] OpMin = 3'b001;
    localparam logic [2:0] OpMax = 3'b010;
    localparam logic [2:0] OpEq  = 3'b011;
    localparam logic [2:0] OpLt  = 3'b100;
    localparam logic [2:0] OpLe  = 3'b101;

    localparam logic [W-1:0]   CanonNan = {1'b0, {(W-1){1'b1}}};
    localparam logic [IDX_W:0] CntOne   = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    function automatic logic is_nan(input logic [W-1:0] x);
        return &x[W-2:0];
    endfunction

    function automatic logic is_zero(input logic [W-1:0] x);
        return ~|x[W-2:0];
    endfunction

    // Strict less-than for non-NaN operands; +0 and -0 are equal.
    function automatic logic f_lt(input logic [W-1:0] x, input logic [W-1:0] y);
        if (is_zero(x) && is_zero(y)) return 1'b0;
        if (x[W-1] != y[W-1]) return x[W-1];
        if (x[W-1]) return x[W-2:0] > y[W-2:0];
        return x[W-2:0] < y[W-2:0];
    endfunction

    function automatic logic f_eq(input logic [W-1:0] x, input logic [W-1:0] y);
        return (is_zero(x) && is_zero(y)) || (x == y);
    endfunction

    // x strictly beats y; opposite-signed zeros are ordered -0 < +0 here.
    function automatic logic better(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic want_max);
        logic zz;
        zz = is_zero(x) & is_zero(y);
        if (want_max) return f_lt(y, x) | (zz & ~x[W-1] & y[W-1]);
        return f_lt(x, y) | (zz & x[W-1] & ~y[W-1]);
    endfunction

    state_e           state_q, state_d;
    logic             rmax_q, rmax_d;
    logic             has_q, has_d;
    logic [W-1:0]     best_q, best_d;
    logic [IDX_W-1:0] bidx_q, bidx_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             inv_q, inv_d;
    logic             ovf_q, ovf_d;

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_data_q, s1_data_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic [4:0]       s1_flags_q, s1_flags_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     s2_data_q, s2_data_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
    logic [4:0]       s2_flags_q, s2_flags_d;

    logic             en, accept, in_acc, red_beat, cur_max, cur_has, cur_inv, cur_ovf;
    logic [W-1:0]     cur_best;
    logic [IDX_W-1:0] cur_idx, elem_idx;
    logic [IDX_W:0]   cur_cnt;
    logic             elem_nan, take, nxt_has, nxt_inv, nxt_ovf;
    logic [W-1:0]     nxt_best;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W:0]   nxt_cnt;
    logic             a_nan, b_nan, beat_inv, pred;
    logic [W-1:0]     beat_data;

    always_comb begin
        en       = out_ready | ~s2_valid_q;
        accept   = in_valid & en;
        in_acc   = (state_q == StAcc);
        red_beat = in_acc | (op[2] & op[1]);

        // In IDLE the accumulator is treated as empty and the op comes from the bus.
        cur_max  = in_acc ? rmax_q : op[0];
        cur_has  = in_acc & has_q;
        cur_best = best_q;
        cur_idx  = bidx_q;
        cur_cnt  = in_acc ? cnt_q : '0;
        cur_inv  = in_acc & inv_q;
        cur_ovf  = in_acc & ovf_q;

        elem_nan = is_nan(a);
        elem_idx = cur_cnt[IDX_W] ? {IDX_W{1'b1}} : cur_cnt[IDX_W-1:0];
        take     = ~elem_nan & (~cur_has | better(a, cur_best, cur_max));
        nxt_has  = cur_has | ~elem_nan;
        nxt_best = take ? a : cur_best;
        nxt_idx  = take ? elem_idx : cur_idx;
        nxt_inv  = cur_inv | elem_nan;
        nxt_ovf  = cur_ovf | cur_cnt[IDX_W];
        nxt_cnt  = cur_cnt[IDX_W] ? cur_cnt : cur_cnt + CntOne;

        a_nan     = is_nan(a);
        b_nan     = is_nan(b);
        beat_data = '0;
        beat_inv  = 1'b0;
        pred      = 1'b0;
        case (op)
            OpMin, OpMax: begin
                beat_inv = a_nan | b_nan;
                if (a_nan && b_nan) beat_data = CanonNan;
                else if (a_nan)     beat_data = b;
                else if (b_nan)     beat_data = a;
                else                beat_data = better(b, a, op == OpMax) ? b : a;
            end
            OpEq, OpLt, OpLe: begin
                beat_inv = a_nan | b_nan;
                if (op == OpEq)      pred = f_eq(a, b);
                else if (op == OpLt) pred = f_lt(a, b);
                else                 pred = f_lt(a, b) | f_eq(a, b);
                beat_data = {W{pred & ~beat_inv}};
            end
            default: ;
        endcase

        state_d = state_q;
        rmax_d  = rmax_q;
        has_d   = has_q;
        best_d  = best_q;
        bidx_d  = bidx_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        if (accept && red_beat) begin
            if (in_last) begin
                state_d = StIdle;
            end else begin
                state_d = StAcc;
                rmax_d  = cur_max;
                has_d   = nxt_has;
                best_d  = nxt_best;
                bidx_d  = nxt_idx;
                cnt_d   = nxt_cnt;
                inv_d   = nxt_inv;
                ovf_d   = nxt_ovf;
            end
        end

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_idx_d   = s1_idx_q;
        s1_flags_d = s1_flags_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_idx_d   = s2_idx_q;
        s2_flags_d = s2_flags_q;
        if (en) begin
            s1_valid_d = accept & (~red_beat | in_last);
            if (red_beat) begin
                s1_data_d  = nxt_has ? nxt_best : CanonNan;
                s1_idx_d   = nxt_has ? nxt_idx : '0;
                s1_flags_d = {nxt_inv, 1'b0, nxt_ovf, 2'b00};
            end else begin
                s1_data_d  = beat_data;
                s1_idx_d   = '0;
                s1_flags_d = {beat_inv, 4'b0000};
            end
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_data_q;
            s2_idx_d   = s1_idx_q;
            s2_flags_d = s1_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rmax_q     <= 1'b0;
            has_q      <= 1'b0;
            best_q     <= '0;
            bidx_q     <= '0;
            cnt_q      <= '0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_idx_q   <= '0;
            s1_flags_q <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_idx_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            state_q    <= state_d;
            rmax_q     <= rmax_d;
            has_q      <= has_d;
            best_q     <= best_d;
            bidx_q     <= bidx_d;
            cnt_q      <= cnt_d;
            inv_q      <= inv_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_idx_q   <= s1_idx_d;
            s1_flags_q <= s1_flags_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_idx_q   <= s2_idx_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_idx   = s2_idx_q;
    assign out_flags = s2_flags_q;

endmodule
